freq_ctrl: RTL

FREQ_CTRL -- requirements
Module: freq_ctrl

---
 rtl/freq_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/freq_ctrl.sv
// freq_ctrl: steps the clock-generator frequency select through 0/33/66/100 MHz.
// Changes come from a direct load, a pushbutton or an automatic dwell timer.
// After every change the block holds off further changes for SETTLE_CYCLES.
// Optional build macro FREQ_CTRL_DEBOUNCE_EN adds a debounce filter on the
// synchronized button; without it the synchronized button is used directly.
module freq_ctrl #(
  parameter int SETTLE_CYCLES   = 16,
  parameter int DWELL_CYCLES    = 1000000,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_btn,
  input  logic       i_auto,
  input  logic       i_load_valid,
  input  logic [1:0] i_load_state,
  output logic       o_load_ready,
  output logic [1:0] o_freq_state,
  output logic       o_settled,
  output logic       o_change
);

  typedef enum logic {
    SETTLE = 1'b0,
    RUN    = 1'b1
  } state_t;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [23:0] DWELL_LAST  = 24'(DWELL_CYCLES - 1);

  logic        btn_meta;
  logic        btn_sync;
  logic        btn_level;
  logic        btn_prev;
  logic        btn_event;
  logic        handshake;

  state_t      state;
  state_t      state_nx;
  logic [15:0] settle_cnt;
  logic [15:0] settle_cnt_nx;
  logic [23:0] dwell_cnt;
  logic [23:0] dwell_cnt_nx;
  logic [1:0]  freq_nx;
  logic        change_nx;

  // Bring the asynchronous pushbutton into the clock domain before any use.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= i_btn;
      btn_sync <= btn_meta;
    end
  end

`ifdef FREQ_CTRL_DEBOUNCE_EN
  localparam logic [19:0] DEBOUNCE_LAST = 20'(DEBOUNCE_CYCLES - 1);

  logic        db_level;
  logic [19:0] db_cnt;

  // Debounced level follows the synchronized button only after it has disagreed long enough.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      db_level <= 1'b0;
      db_cnt   <= '0;
    end else if (btn_sync == db_level) begin
      db_cnt   <= '0;
    end else if (db_cnt == DEBOUNCE_LAST) begin
      db_level <= btn_sync;
      db_cnt   <= '0;
    end else begin
      db_cnt   <= db_cnt + 20'd1;
    end
  end

  assign btn_level = db_level;
`else
  assign btn_level = btn_sync;
`endif

  // Remember the previous button level so a press is seen only on its rising edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      btn_prev <= 1'b0;
    end else begin
      btn_prev <= btn_level;
    end
  end

  assign btn_event = btn_level & ~btn_prev;
  assign handshake = i_load_valid & o_load_ready;

  // State, counters and all outputs are registered from the next-state logic.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= SETTLE;
      settle_cnt   <= '0;
      dwell_cnt    <= '0;
      o_freq_state <= 2'b00;
      o_change     <= 1'b0;
      o_settled    <= 1'b0;
      o_load_ready <= 1'b0;
    end else begin
      state        <= state_nx;
      settle_cnt   <= settle_cnt_nx;
      dwell_cnt    <= dwell_cnt_nx;
      o_freq_state <= freq_nx;
      o_change     <= change_nx;
      o_settled    <= (state_nx == RUN);
      o_load_ready <= (state_nx == RUN);
    end
  end

  // Next state: load beats button beats auto-step; anything lower in the same cycle is dropped.
  always_comb begin
    state_nx      = state;
    settle_cnt_nx = settle_cnt;
    dwell_cnt_nx  = dwell_cnt;
    freq_nx       = o_freq_state;
    change_nx     = 1'b0;

    case (state)
      SETTLE: begin
        dwell_cnt_nx = '0;
        if (settle_cnt == SETTLE_LAST) begin
          state_nx      = RUN;
          settle_cnt_nx = '0;
        end else begin
          settle_cnt_nx = settle_cnt + 16'd1;
        end
      end

      RUN: begin
        if (handshake) begin
          dwell_cnt_nx = '0;
          if (i_load_state != o_freq_state) begin
            freq_nx   = i_load_state;
            change_nx = 1'b1;
          end
        end else if (btn_event) begin
          freq_nx   = o_freq_state + 2'd1;
          change_nx = 1'b1;
        end else if (!i_auto) begin
          dwell_cnt_nx = '0;
        end else if (dwell_cnt == DWELL_LAST) begin
          freq_nx   = o_freq_state + 2'd1;
          change_nx = 1'b1;
        end else begin
          dwell_cnt_nx = dwell_cnt + 24'd1;
        end

        if (change_nx) begin
          state_nx      = SETTLE;
          settle_cnt_nx = '0;
          dwell_cnt_nx  = '0;
        end
      end

      default: begin
        state_nx = SETTLE;
      end
    endcase
  end

endmodule
